// File: rtl/m1_pkg.sv
// Shared constants, widths and state encoding for the M1 frame serializer.
package m1_pkg;

  localparam int WORD_BITS       = 12;
  localparam int WORDS_PER_FRAME = 128;
  localparam int GROUPS          = 32;

  localparam int PTR_W     = $clog2(WORDS_PER_FRAME);
  localparam int GRP_W     = $clog2(GROUPS);
  localparam int BIT_CNT_W = $clog2(WORD_BITS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    SHIFT = 2'd2
  } state_t;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(WORDS_PER_FRAME - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  function automatic logic [GRP_W-1:0] grp_inc(input logic [GRP_W-1:0] g);
    return (g == GRP_W'(GROUPS - 1)) ? '0 : g + GRP_W'(1);
  endfunction

endpackage

// File: rtl/m1_bit_timer.sv
// Serial bit-period divider: bit strobe, last-clock flag and half-bit flag.
// Half-bit flag is only live when M1_SER_MANCHESTER_EN is defined.
module m1_bit_timer #(
  parameter int CLK_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic bit_strobe,
  output logic bit_last,
  output logic half
);

  localparam int DIV_W = $clog2(CLK_PER_BIT);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_PER_BIT - 1);

  if (CLK_PER_BIT < 3) begin : g_bad_div
    $error("m1_bit_timer: CLK_PER_BIT must be at least 3");
  end

  logic [DIV_W-1:0] div_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
    end else if (clear) begin
      div_cnt <= '0;
    end else if (enable) begin
      div_cnt <= (div_cnt == DIV_MAX) ? '0 : div_cnt + DIV_W'(1);
    end
  end

  assign bit_strobe = enable && (div_cnt == '0);
  assign bit_last   = enable && (div_cnt == DIV_MAX);

`ifdef M1_SER_MANCHESTER_EN
  if ((CLK_PER_BIT % 2) != 0) begin : g_bad_half
    $error("m1_bit_timer: CLK_PER_BIT must be even for Manchester coding");
  end

  localparam logic [DIV_W-1:0] HALF_CNT = DIV_W'(CLK_PER_BIT / 2);
  assign half = enable && (div_cnt >= HALF_CNT);
`else
  assign half = 1'b0;
`endif

endmodule

// File: rtl/m1_frame_serializer.sv
// Pulls 12-bit words from the M1 filler and shifts them out MSB-first.
// Define M1_SER_MANCHESTER_EN for Manchester line coding instead of NRZ.
module m1_frame_serializer
  import m1_pkg::*;
#(
  parameter int CLK_PER_BIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic [WORD_BITS-1:0] dataWord,
  output logic                 bufGetWord,
  output logic [PTR_W-1:0]     bufRdPointer,
  output logic [GRP_W-1:0]     cntGrp,
  output logic                 serOut,
  output logic                 bitStrobe,
  output logic                 wordStart,
  output logic                 frameStart,
  output logic                 busy
);

  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(WORD_BITS - 1);
  localparam logic [PTR_W-1:0]     LAST_PTR = PTR_W'(WORDS_PER_FRAME - 1);

  state_t                 state, state_next;
  logic [WORD_BITS-1:0]   sh_reg;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic                   prefetched;
  logic                   prime_cnt;
  logic                   in_shift;
  logic                   last_bit;
  logic                   get_word;
  logic                   load_word;
  logic                   bit_strobe;
  logic                   bit_last;
  logic                   half;

  assign in_shift = (state == SHIFT);
  assign last_bit = (bit_cnt == LAST_BIT);

  m1_bit_timer #(
    .CLK_PER_BIT (CLK_PER_BIT)
  ) u_bit_timer (
    .clk        (clk),
    .reset      (reset),
    .enable     (in_shift),
    .clear      (!in_shift),
    .bit_strobe (bit_strobe),
    .bit_last   (bit_last),
    .half       (half)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The prefetch strobe (first clk of the last bit) and the word-boundary
  // load (last clk of the last bit) never coincide since CLK_PER_BIT >= 3.
  always_comb begin
    state_next = state;
    get_word   = 1'b0;
    load_word  = 1'b0;
    case (state)
      IDLE: begin
        if (run) begin
          get_word   = 1'b1;
          state_next = PRIME;
        end
      end
      PRIME: begin
        if (prime_cnt) begin
          load_word  = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_strobe && last_bit && run) begin
          get_word = 1'b1;
        end
        if (bit_last && last_bit) begin
          if (prefetched) begin
            load_word = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bufGetWord = get_word && reset;
    wordStart  = load_word;
    frameStart = load_word && (bufRdPointer == '0);
    bitStrobe  = bit_strobe;
    busy       = (state != IDLE);
    serOut     = in_shift && (sh_reg[WORD_BITS-1] ^ half);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prime_cnt <= 1'b0;
    end else if (state == PRIME) begin
      prime_cnt <= !prime_cnt;
    end else begin
      prime_cnt <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prefetched <= 1'b0;
    end else if (!in_shift || load_word) begin
      prefetched <= 1'b0;
    end else if (get_word) begin
      prefetched <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh_reg <= '0;
    end else if (load_word) begin
      sh_reg <= dataWord;
    end else if (in_shift && bit_last) begin
      sh_reg <= {sh_reg[WORD_BITS-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt <= '0;
    end else if (!in_shift || load_word) begin
      bit_cnt <= '0;
    end else if (bit_last) begin
      bit_cnt <= bit_cnt + BIT_CNT_W'(1);
    end
  end

  // Address and group only move on a load clk, so a request strobe always
  // sees a stable pointer; a new frame's first request sees the new group.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bufRdPointer <= '0;
      cntGrp       <= '0;
    end else if (load_word) begin
      bufRdPointer <= ptr_inc(bufRdPointer);
      if (bufRdPointer == LAST_PTR) begin
        cntGrp <= grp_inc(cntGrp);
      end
    end
  end

endmodule

// File: tb/tb_m1_frame_serializer.sv
// Directed bench for m1_frame_serializer (CLK_PER_BIT=4) with a simple word filler.
module tb_m1_frame_serializer;

  localparam bit MAN =
`ifdef M1_SER_MANCHESTER_EN
    1'b1;
`else
    1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [11:0] dataWord = 12'h000;
  logic        bufGetWord;
  logic [6:0]  bufRdPointer;
  logic [4:0]  cntGrp;
  logic        serOut, bitStrobe, wordStart, frameStart, busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  m1_frame_serializer #(.CLK_PER_BIT(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .run          (run),
    .dataWord     (dataWord),
    .bufGetWord   (bufGetWord),
    .bufRdPointer (bufRdPointer),
    .cntGrp       (cntGrp),
    .serOut       (serOut),
    .bitStrobe    (bitStrobe),
    .wordStart    (wordStart),
    .frameStart   (frameStart),
    .busy         (busy)
  );

  // Filler: word for address p is 12'hA5C ^ p, valid the clk after the strobe.
  always @(posedge clk) begin
    if (bufGetWord) dataWord <= 12'hA5C ^ {5'b0, bufRdPointer};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int         cyc;
    logic       get, ws, fs, bs, bsy, ser;
    logic [6:0] ptr;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int          ti;
    int          ws_cnt;
    int          fs_cnt;
    int          get_cnt;
    bit          done;
    logic [11:0] word_a;
    logic [11:0] word_b;
    logic        exp_bit;

    // cycle 0 = first clk after reset release with run=1
    tbl[0]  = '{0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,        7'd0};
    tbl[1]  = '{1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,        7'd0};
    tbl[2]  = '{2,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0,        7'd0};
    tbl[3]  = '{3,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,        7'd1};
    tbl[4]  = '{4,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,        7'd1};
    tbl[5]  = '{7,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0,        7'd1};
    tbl[6]  = '{47, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0,        7'd1};
    tbl[7]  = '{48, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,        7'd1};
    tbl[8]  = '{50, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, MAN,         7'd1};
    tbl[9]  = '{51, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,        7'd2};
    tbl[10] = '{95, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,        7'd2};
    tbl[11] = '{98, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1 ^ MAN,  7'd2};

    word_a = 12'hA5C;
    word_b = 12'hA5D;
    ws_cnt = 0;
    fs_cnt = 0;

    reset = 1'b0;
    run   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs",
          32'({bufGetWord, wordStart, frameStart, bitStrobe, busy, serOut, bufRdPointer, cntGrp}), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    ti = 0;
    for (int c = 0; c <= 98; c++) begin
      @(negedge clk);
      if (wordStart)  ws_cnt++;
      if (frameStart) fs_cnt++;
      if (ti < 12 && tbl[ti].cyc == c) begin
        check($sformatf("vec_c%0d", c),
              32'({bufGetWord, wordStart, frameStart, bitStrobe, busy, serOut, bufRdPointer}),
              32'({tbl[ti].get, tbl[ti].ws, tbl[ti].fs, tbl[ti].bs, tbl[ti].bsy, tbl[ti].ser, tbl[ti].ptr}));
        ti++;
      end
      if (c >= 3 && c < 51) begin
        exp_bit = word_a[11 - (c - 3) / 4] ^ (MAN && ((c - 3) % 4) >= 2);
        check($sformatf("ser_w0_c%0d", c), 32'(serOut), 32'(exp_bit));
      end
      if (c == 51) check("ser_w1_msb", 32'(serOut), 32'(word_b[11]));
      @(posedge clk);
      #1;
    end

    // Stream through a frame wrap: load n carries address n mod 128.
    done = 1'b0;
    for (int c = 0; c < 140 * 48 && !done; c++) begin
      @(negedge clk);
      if (bufGetWord && bufRdPointer == 7'd0) check("grp_at_frame_req", 32'(cntGrp), 32'd1);
      if (wordStart) begin
        check($sformatf("wrap_ptr_n%0d", ws_cnt), 32'(bufRdPointer), 32'(ws_cnt % 128));
        check($sformatf("wrap_fs_n%0d", ws_cnt), 32'(frameStart), 32'(ws_cnt % 128 == 0));
        if (ws_cnt == 127) check("grp_before_wrap", 32'(cntGrp), 32'd0);
        if (ws_cnt == 128) check("grp_after_wrap", 32'(cntGrp), 32'd1);
        if (frameStart) fs_cnt++;
        ws_cnt++;
        if (ws_cnt == 130) done = 1'b1;
      end
      if (!done) begin
        @(posedge clk);
        #1;
      end
    end
    check("wrap_reached", 32'(done), 32'd1);
    check("fs_per_128_ws", 32'(fs_cnt), 32'd2);

    // Asynchronous reset in the middle of a word (bitCnt 6).
    repeat (25) @(posedge clk);
    #2;
    check("mid_word_strobe", 32'({busy, bitStrobe}), 32'b11);
    reset = 1'b0;
    #1;
    check("async_reset_outputs",
          32'({bufGetWord, wordStart, frameStart, bitStrobe, busy, serOut, bufRdPointer, cntGrp}), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("restart_req", 32'({bufGetWord, bufRdPointer, cntGrp}), 32'({1'b1, 7'd0, 5'd0}));

    // Stream to word 7, then drop run at its bitCnt 5.
    ws_cnt = 0;
    done   = 1'b0;
    for (int c = 0; c < 10 * 48 && !done; c++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      if (wordStart) begin
        if (ws_cnt == 0) check("restart_first_load", 32'({frameStart, bufRdPointer}), 32'({1'b1, 7'd0}));
        if (ws_cnt == 7) begin
          check("word7_load_ptr", 32'(bufRdPointer), 32'd7);
          done = 1'b1;
        end
        ws_cnt++;
      end
    end
    check("word7_reached", 32'(done), 32'd1);
    repeat (21) @(posedge clk);
    #1;
    run = 1'b0;
    get_cnt = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (bufGetWord) get_cnt++;
      if (t == 27) check("word7_last_clk_busy", 32'(busy), 32'd1);
      if (t == 28) check("idle_after_word7", 32'({busy, serOut, bitStrobe}), 32'd0);
      @(posedge clk);
      #1;
    end
    check("no_req_after_drop", 32'(get_cnt), 32'd0);
    check("idle_ptr_retained", 32'(bufRdPointer), 32'd8);
    run = 1'b1;
    @(negedge clk);
    check("resume_req_ptr8", 32'({bufGetWord, bufRdPointer, cntGrp}), 32'({1'b1, 7'd8, 5'd0}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
